udma_stream_sink: RTL and testbench

Stream-to-L2 writer for the uDMA stream fabric. It accepts beats from the shared in-stream bus that are addressed to this instance and buffers them in a small FIFO. It writes them into a circular L2 region through an RX channel port. For every completed L2 write it issues a write notification (spoof) beat, so a downstream stream reader can track the write pointer and replay the data.

---
 rtl/udma_stream_sink.sv | 186 ++++++++++++++++++
 tb/tb_udma_stream_sink.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_stream_sink.sv
// Stream-to-L2 writer: buffers in-stream beats addressed to this instance and writes
// them into a circular L2 region, emitting a spoof notification beat for every write.
module udma_stream_sink #(
    parameter int L2_AWIDTH_NOAL  = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int STREAM_ID_WIDTH = 2,
    parameter int INST_ID         = 0,
    parameter int BUFFER_DEPTH    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cmd_clr_i,
    input  logic                       cfg_start_i,
    input  logic [L2_AWIDTH_NOAL-1:0]  cfg_addr_i,
    input  logic [L2_AWIDTH_NOAL-1:0]  cfg_size_i,
    input  logic [STREAM_ID_WIDTH-1:0] in_stream_dest_i,
    input  logic [DATA_WIDTH-1:0]      in_stream_data_i,
    input  logic [1:0]                 in_stream_datasize_i,
    input  logic                       in_stream_valid_i,
    input  logic                       in_stream_sot_i,
    input  logic                       in_stream_eot_i,
    output logic                       in_stream_ready_o,
    output logic                       rx_ch_valid_o,
    output logic [L2_AWIDTH_NOAL-1:0]  rx_ch_addr_o,
    output logic [DATA_WIDTH-1:0]      rx_ch_data_o,
    output logic [1:0]                 rx_ch_datasize_o,
    input  logic                       rx_ch_ready_i,
    output logic                       spoof_req_o,
    output logic                       spoof_gnt_o,
    output logic [L2_AWIDTH_NOAL-1:0]  spoof_addr_o,
    output logic [STREAM_ID_WIDTH-1:0] spoof_dest_o,
    output logic [1:0]                 spoof_datasize_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [L2_AWIDTH_NOAL-1:0]  bytes_o
);

    localparam int AW    = L2_AWIDTH_NOAL;
    localparam int PTR_W = $clog2(BUFFER_DEPTH);
    localparam int ENT_W = DATA_WIDTH + 3;
    localparam logic [STREAM_ID_WIDTH-1:0] DEST_ID = STREAM_ID_WIDTH'(INST_ID);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state, state_nxt;

    logic [ENT_W-1:0]      mem [BUFFER_DEPTH];
    logic [PTR_W:0]        wr_ptr, rd_ptr;
    logic                  fifo_empty, fifo_full, push, pop, start_ok;
    logic [ENT_W-1:0]      head;
    logic [DATA_WIDTH-1:0] head_data;
    logic [1:0]            head_size;
    logic                  head_eot;

    logic [AW-1:0]         base_q, size_q, offset_q, bytes_q, wr_addr;
    logic                  spoof_vld_p0;
    logic [AW-1:0]         spoof_addr_p0;
    logic [1:0]            spoof_size_p0;
    logic                  sot_unused;

    function automatic logic [AW-1:0] size_to_inc(input logic [1:0] ds);
        case (ds)
            2'b00:   return AW'(1);
            2'b01:   return AW'(2);
            default: return AW'(4);
        endcase
    endfunction

    // Wrap is an exact >= compare on the unwrapped sum, so a straddling write still goes out.
    function automatic logic [AW-1:0] next_offset(input logic [AW-1:0] off,
                                                  input logic [AW-1:0] inc,
                                                  input logic [AW-1:0] size);
        logic [AW:0] nxt;
        nxt = {1'b0, off} + {1'b0, inc};
        if ((size != '0) && (nxt >= {1'b0, size}))
            return '0;
        return nxt[AW-1:0];
    endfunction

    assign sot_unused = in_stream_sot_i;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head       = mem[rd_ptr[PTR_W-1:0]];
    assign head_data  = head[ENT_W-1:3];
    assign head_size  = head[2:1];
    assign head_eot   = head[0];
    assign push       = in_stream_valid_i & in_stream_ready_o;
    assign pop        = ~fifo_empty & rx_ch_ready_i;
    assign start_ok   = (state == IDLE) & cfg_start_i & ~cmd_clr_i;
    assign wr_addr    = base_q + offset_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_start_i) state_nxt = RUN;
            RUN:     if (push && in_stream_eot_i) state_nxt = DRAIN;
            DRAIN:   if (pop && head_eot) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cmd_clr_i)
            state_nxt = IDLE;
    end

    always_comb begin
        busy_o            = (state != IDLE);
        in_stream_ready_o = (state == RUN) & ~fifo_full & (in_stream_dest_i == DEST_ID);
        done_o            = (state == DRAIN) & pop & head_eot & ~cmd_clr_i;
    end

    // FIFO pointers (control) and storage (data, not reset)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (cmd_clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr[PTR_W-1:0]] <= {in_stream_data_i, in_stream_datasize_i, in_stream_eot_i};
    end

    // Ring configuration survives a clear; only start reloads it
    always_ff @(posedge clk_i) begin
        if (start_ok) begin
            base_q <= cfg_addr_i;
            size_q <= cfg_size_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            offset_q <= '0;
            bytes_q  <= '0;
        end else if (cmd_clr_i || start_ok) begin
            offset_q <= '0;
            bytes_q  <= '0;
        end else if (pop) begin
            offset_q <= next_offset(offset_q, size_to_inc(head_size), size_q);
            bytes_q  <= bytes_q + size_to_inc(head_size);
        end
    end

    // Stage p0: spoof notification for the write handshaked last cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            spoof_vld_p0 <= 1'b0;
        else
            spoof_vld_p0 <= pop & ~cmd_clr_i;
    end

    always_ff @(posedge clk_i) begin
        if (pop) begin
            spoof_addr_p0 <= wr_addr;
            spoof_size_p0 <= head_size;
        end
    end

    assign rx_ch_valid_o    = ~fifo_empty;
    assign rx_ch_addr_o     = fifo_empty ? '0 : wr_addr;
    assign rx_ch_data_o     = fifo_empty ? '0 : head_data;
    assign rx_ch_datasize_o = fifo_empty ? '0 : head_size;

    assign spoof_req_o      = spoof_vld_p0;
    assign spoof_gnt_o      = spoof_vld_p0;
    assign spoof_addr_o     = spoof_vld_p0 ? spoof_addr_p0 : '0;
    assign spoof_datasize_o = spoof_vld_p0 ? spoof_size_p0 : '0;
    assign spoof_dest_o     = DEST_ID;
    assign bytes_o          = bytes_q;

endmodule

// File: tb/tb_udma_stream_sink.sv
// Scoreboard bench for udma_stream_sink: accepted beats queue expected writes,
// which are popped and compared when the DUT handshakes on the RX channel.
`timescale 1ns/1ps
module tb_udma_stream_sink;
    localparam int AW = 16, DW = 32, IW = 2, INST = 0, DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_i, cmd_clr_i, cfg_start_i;
    logic [AW-1:0] cfg_addr_i, cfg_size_i;
    logic [IW-1:0] in_stream_dest_i;
    logic [DW-1:0] in_stream_data_i;
    logic [1:0]    in_stream_datasize_i;
    logic          in_stream_valid_i, in_stream_sot_i, in_stream_eot_i, in_stream_ready_o;
    logic          rx_ch_valid_o, rx_ch_ready_i;
    logic [AW-1:0] rx_ch_addr_o;
    logic [DW-1:0] rx_ch_data_o;
    logic [1:0]    rx_ch_datasize_o;
    logic          spoof_req_o, spoof_gnt_o;
    logic [AW-1:0] spoof_addr_o;
    logic [IW-1:0] spoof_dest_o;
    logic [1:0]    spoof_datasize_o;
    logic          busy_o, done_o;
    logic [AW-1:0] bytes_o;

    always #5 clk_i = ~clk_i;

    udma_stream_sink #(
        .L2_AWIDTH_NOAL(AW), .DATA_WIDTH(DW), .STREAM_ID_WIDTH(IW),
        .INST_ID(INST), .BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cmd_clr_i(cmd_clr_i),
        .cfg_start_i(cfg_start_i), .cfg_addr_i(cfg_addr_i), .cfg_size_i(cfg_size_i),
        .in_stream_dest_i(in_stream_dest_i), .in_stream_data_i(in_stream_data_i),
        .in_stream_datasize_i(in_stream_datasize_i), .in_stream_valid_i(in_stream_valid_i),
        .in_stream_sot_i(in_stream_sot_i), .in_stream_eot_i(in_stream_eot_i),
        .in_stream_ready_o(in_stream_ready_o),
        .rx_ch_valid_o(rx_ch_valid_o), .rx_ch_addr_o(rx_ch_addr_o), .rx_ch_data_o(rx_ch_data_o),
        .rx_ch_datasize_o(rx_ch_datasize_o), .rx_ch_ready_i(rx_ch_ready_i),
        .spoof_req_o(spoof_req_o), .spoof_gnt_o(spoof_gnt_o), .spoof_addr_o(spoof_addr_o),
        .spoof_dest_o(spoof_dest_o), .spoof_datasize_o(spoof_datasize_o),
        .busy_o(busy_o), .done_o(done_o), .bytes_o(bytes_o)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    ds;
        logic          eot;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] obs_addr[$];
    logic [AW-1:0] ea[$];
    int            n_tests = 0, n_fail = 0, done_cnt = 0, acc_cnt = 0;
    logic [AW-1:0] m_base = '0, m_size = '0, m_off = '0, m_bytes = '0;
    logic          prev_pop = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [1:0]    prev_ds;
    exp_t          mon_e;
    logic [AW:0]   mon_nxt;
    logic [AW-1:0] mon_inc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] beat_bytes(input logic [1:0] ds);
        return (ds == 2'b00) ? AW'(1) : (ds == 2'b01) ? AW'(2) : AW'(4);
    endfunction

    // Monitor/scoreboard, sampling on the falling edge
    always @(negedge clk_i) begin
        if (rst_i || cmd_clr_i) begin
            exp_q.delete();
            prev_pop = 1'b0;
        end else begin
            check("spoof_req", spoof_req_o, prev_pop);
            check("spoof_gnt", spoof_gnt_o, prev_pop);
            if (prev_pop) begin
                check("spoof_addr", spoof_addr_o, prev_addr);
                check("spoof_ds", spoof_datasize_o, prev_ds);
            end
            prev_pop = 1'b0;
            if (rx_ch_valid_o && rx_ch_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", rx_ch_addr_o, mon_e.addr);
                    check("wr_data", rx_ch_data_o, mon_e.data);
                    check("wr_ds", rx_ch_datasize_o, mon_e.ds);
                    check("done_at_pop", done_o, mon_e.eot);
                    prev_pop  = 1'b1;
                    prev_addr = mon_e.addr;
                    prev_ds   = mon_e.ds;
                end
                obs_addr.push_back(rx_ch_addr_o);
            end else begin
                check("done_no_pop", done_o, 0);
            end
            if (done_o) done_cnt++;
            if (in_stream_valid_i && in_stream_ready_o) begin
                acc_cnt++;
                mon_inc   = beat_bytes(in_stream_datasize_i);
                mon_e.addr = m_base + m_off;
                mon_e.data = in_stream_data_i;
                mon_e.ds   = in_stream_datasize_i;
                mon_e.eot  = in_stream_eot_i;
                exp_q.push_back(mon_e);
                mon_nxt = {1'b0, m_off} + {1'b0, mon_inc};
                if (m_size != '0 && mon_nxt >= {1'b0, m_size}) m_off = '0;
                else m_off = mon_nxt[AW-1:0];
                m_bytes = m_bytes + mon_inc;
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] size);
        m_base = base; m_size = size; m_off = '0; m_bytes = '0;
        obs_addr.delete(); done_cnt = 0; acc_cnt = 0;
        cfg_addr_i = base; cfg_size_i = size; cfg_start_i = 1'b1;
        @(posedge clk_i); #1;
        cfg_start_i = 1'b0;
    endtask

    task automatic send_beat(input logic [IW-1:0] dest, input logic [DW-1:0] data,
                             input logic [1:0] ds, input logic eot);
        bit acc = 0;
        in_stream_dest_i = dest; in_stream_data_i = data; in_stream_datasize_i = ds;
        in_stream_eot_i = eot; in_stream_sot_i = 1'b0; in_stream_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (in_stream_ready_o) begin acc = 1; break; end
        end
        @(posedge clk_i); #1;
        in_stream_valid_i = 1'b0; in_stream_eot_i = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (!busy_o) begin ok = 1; break; end
        end
        if (!ok) check({tag, "_idle_timeout"}, 0, 1);
        @(posedge clk_i); #1;
    endtask

    task automatic check_addrs(input string tag);
        check({tag, "_nwrites"}, obs_addr.size(), ea.size());
        foreach (ea[i])
            if (i < obs_addr.size()) check($sformatf("%s_addr%0d", tag, i), obs_addr[i], ea[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; cmd_clr_i = 1'b0; cfg_start_i = 1'b0; cfg_addr_i = '0; cfg_size_i = '0;
        in_stream_dest_i = '0; in_stream_data_i = '0; in_stream_datasize_i = '0;
        in_stream_valid_i = 1'b0; in_stream_sot_i = 1'b0; in_stream_eot_i = 1'b0;
        rx_ch_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_rx_valid", rx_ch_valid_o, 0);
        check("rst_rx_addr", rx_ch_addr_o, 0);
        check("rst_rx_data", rx_ch_data_o, 0);
        check("rst_spoof_req", spoof_req_o, 0);
        check("rst_spoof_addr", spoof_addr_o, 0);
        check("rst_spoof_dest", spoof_dest_o, INST);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_bytes", bytes_o, 0);
        check("rst_ready", in_stream_ready_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Basic transfer
        rx_ch_ready_i = 1'b1;
        do_start(16'h100, 16'h10);
        check("basic_busy", busy_o, 1);
        send_beat(0, 32'hA000_0000, 2'b10, 0);
        send_beat(0, 32'hA000_0001, 2'b10, 0);
        send_beat(0, 32'hA000_0002, 2'b10, 1);
        wait_idle("basic");
        ea = '{16'h100, 16'h104, 16'h108};
        check_addrs("basic");
        check("basic_bytes", bytes_o, 12);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_busy_fall", busy_o, 0);

        // Ring wrap
        do_start(16'h200, 16'h8);
        for (int i = 0; i < 5; i++) send_beat(0, 32'hC000_0000 + i, 2'b10, (i == 4));
        wait_idle("wrap");
        ea = '{16'h200, 16'h204, 16'h200, 16'h204, 16'h200};
        check_addrs("wrap");
        check("wrap_bytes", bytes_o, 20);

        // Mixed datasizes
        do_start(16'h40, 16'h0);
        send_beat(0, 32'h0000_0011, 2'b00, 0);
        send_beat(0, 32'h0000_2233, 2'b01, 0);
        send_beat(0, 32'h4455_6677, 2'b10, 1);
        wait_idle("mixed");
        ea = '{16'h40, 16'h41, 16'h43};
        check_addrs("mixed");
        check("mixed_bytes", bytes_o, 7);

        // Backpressure: FIFO fills, head held stable
        rx_ch_ready_i = 1'b0;
        do_start(16'h400, 16'h0);
        for (int i = 0; i < 4; i++) send_beat(0, 32'hB000_0000 + i, 2'b10, 0);
        in_stream_dest_i = 0; in_stream_data_i = 32'hB000_0004; in_stream_datasize_i = 2'b10;
        in_stream_eot_i = 1'b0; in_stream_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check("bp_ready_low", in_stream_ready_o, 0);
            check("bp_rx_valid", rx_ch_valid_o, 1);
            check("bp_rx_addr_stable", rx_ch_addr_o, 16'h400);
            check("bp_rx_data_stable", rx_ch_data_o, 32'hB000_0000);
        end
        check("bp_accepted", acc_cnt, 4);
        @(posedge clk_i); #1;
        rx_ch_ready_i = 1'b1;
        send_beat(0, 32'hB000_0004, 2'b10, 0);
        send_beat(0, 32'hB000_0005, 2'b10, 1);
        wait_idle("bp");
        ea = '{16'h400, 16'h404, 16'h408, 16'h40C, 16'h410, 16'h414};
        check_addrs("bp");
        check("bp_bytes", bytes_o, 24);

        // Destination filtering
        do_start(16'h500, 16'h0);
        in_stream_dest_i = 1; in_stream_data_i = 32'hDEAD_0000; in_stream_datasize_i = 2'b10;
        in_stream_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("filt_ready", in_stream_ready_o, 0);
            check("filt_rx_valid", rx_ch_valid_o, 0);
        end
        @(posedge clk_i); #1;
        in_stream_valid_i = 1'b0;
        check("filt_nwrites", obs_addr.size(), 0);
        send_beat(0, 32'hDEAD_0001, 2'b10, 1);
        wait_idle("filt");
        ea = '{16'h500};
        check_addrs("filt");

        // Clear with two entries queued, coincident with a would-be pop
        rx_ch_ready_i = 1'b0;
        do_start(16'h300, 16'h0);
        send_beat(0, 32'hD000_0000, 2'b10, 0);
        send_beat(0, 32'hD000_0001, 2'b10, 0);
        @(negedge clk_i);
        check("clr_pre_valid", rx_ch_valid_o, 1);
        @(posedge clk_i); #1;
        cmd_clr_i = 1'b1; rx_ch_ready_i = 1'b1;
        @(posedge clk_i); #1;
        cmd_clr_i = 1'b0;
        done_cnt = 0;
        check("clr_busy", busy_o, 0);
        check("clr_rx_valid", rx_ch_valid_o, 0);
        check("clr_bytes", bytes_o, 0);
        check("clr_spoof", spoof_req_o, 0);
        check("clr_done", done_o, 0);
        repeat (3) @(posedge clk_i);
        #1;
        check("clr_no_done", done_cnt, 0);
        do_start(16'h300, 16'h0);
        send_beat(0, 32'hD000_0002, 2'b10, 1);
        wait_idle("clr_restart");
        ea = '{16'h300};
        check_addrs("clr_restart");
        check("clr_restart_bytes", bytes_o, 4);

        // Asynchronous reset mid-transfer
        do_start(16'h600, 16'h0);
        send_beat(0, 32'hE000_0000, 2'b10, 0);
        repeat (2) @(posedge clk_i);
        #1;
        in_stream_dest_i = 0; in_stream_valid_i = 1'b1;
        check("arst_pre_bytes", bytes_o, 4);
        check("arst_pre_busy", busy_o, 1);
        check("arst_pre_ready", in_stream_ready_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_ready", in_stream_ready_o, 0);
        check("arst_bytes", bytes_o, 0);
        check("arst_rx_valid", rx_ch_valid_o, 0);
        check("arst_spoof_req", spoof_req_o, 0);
        check("arst_spoof_dest", spoof_dest_o, INST);
        check("arst_done", done_o, 0);
        in_stream_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
